// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for both halves of the asynchronous FIFO.
//   DEFAULT_PTR_WIDTH  : default memory address width (depth = 2**width)
//   DEFAULT_DATA_WIDTH : default word width
//   bin2gray / gray2bin: pointer code conversions, operating on a 32-bit
//                        container. Callers zero-extend narrower pointers in
//                        and truncate the result back to their own width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_PTR_WIDTH  = 3;
    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros in the container stay zero, so the conversion is correct
    // for any zero-extended pointer that fits in 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a multi-bit Gray-coded pointer. Shared by the read
// and write sides of the FIFO.
// Parameters:
//   WIDTH : number of bits carried across the clock boundary
// Ports:
//   clk   : destination-domain clock, rising edge
//   rst_n : asynchronous active-low reset, clears both stages
//   d     : value from the foreign clock domain
//   q     : value after the second stage. Only this output may be used.
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;

    // The first stage may go metastable. The second stage gives it a full
    // cycle to resolve before anything downstream sees the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            q     <= '0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/rd_stream_ctrl.sv
// -----------------------------------------------------------------------------
// rd_stream_ctrl
// Read side of an asynchronous FIFO. It synchronizes the write pointer, tracks
// occupancy, and streams the memory out through a one-word registered
// valid/ready output stage.
//
// Configuration macro: RD_LEVEL_EN
//   defined   -> rlevel reports the unread word count. almost_empty asserts
//                when rlevel <= AEMPTY_THRESH.
//   undefined -> rlevel is tied to 0 and almost_empty follows empty. empty
//                comes from a direct pointer comparison.
//
// Parameters:
//   PTR_WIDTH     : memory address width, depth = 2**PTR_WIDTH
//   DATA_WIDTH    : word width
//   AEMPTY_THRESH : almost_empty threshold (RD_LEVEL_EN builds only)
// Ports:
//   rclk, rrst_n  : read clock, asynchronous active-low reset
//   g_wptr        : Gray write pointer, asynchronous to rclk
//   mem_rdata     : combinational memory read data at mem_raddr
//   mem_raddr     : memory read address
//   g_rptr        : registered Gray read pointer toward the write side
//   m_valid/m_ready/m_data : output stream handshake
//   empty         : no unread word in memory (output register excluded)
//   almost_empty  : low-occupancy flag
//   rlevel        : words in memory not yet popped
// -----------------------------------------------------------------------------
module rd_stream_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH     = DEFAULT_PTR_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic [PTR_WIDTH:0]    g_wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [PTR_WIDTH-1:0]  mem_raddr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    rlevel
);

    localparam int PW1 = PTR_WIDTH + 1;

    logic [PTR_WIDTH:0] sync2;
    logic [PTR_WIDTH:0] wbin;
    logic [PTR_WIDTH:0] b_rptr;
    logic [PTR_WIDTH:0] b_rptr_next;
    logic               pop;

    sync_2ff #(
        .WIDTH (PW1)
    ) u_wptr_sync (
        .clk   (rclk),
        .rst_n (rrst_n),
        .d     (g_wptr),
        .q     (sync2)
    );

    assign wbin = PW1'(gray2bin(32'(sync2)));

`ifdef RD_LEVEL_EN
    localparam logic [PTR_WIDTH:0] AE_THRESH = PW1'(AEMPTY_THRESH);

    // The extra pointer MSB makes the modular difference range 0..depth
    // without ambiguity, so a full memory never aliases to empty.
    always_comb begin
        rlevel       = wbin - b_rptr;
        empty        = (rlevel == '0);
        almost_empty = (rlevel <= AE_THRESH);
    end
`else
    always_comb begin
        rlevel       = '0;
        empty        = (wbin == b_rptr);
        almost_empty = empty;
    end
`endif

    // Refill the output register when it is free or is being drained this cycle.
    // A refill can then happen on the same edge as an accept, which sustains one
    // word per cycle.
    assign pop         = !empty && (!m_valid || m_ready);
    assign b_rptr_next = b_rptr + {{PTR_WIDTH{1'b0}}, pop};
    assign mem_raddr   = b_rptr[PTR_WIDTH-1:0];

    // g_rptr is registered from the next binary value. The write side therefore
    // sees a clean single-bit Gray step on the same edge that b_rptr advances.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            b_rptr  <= '0;
            g_rptr  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            b_rptr <= b_rptr_next;
            g_rptr <= PW1'(bin2gray(32'(b_rptr_next)));
            if (pop) begin
                m_data  <= mem_rdata;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
